// File: rtl/instr_mem_fetch.sv
// -----------------------------------------------------------------------------
// instr_mem_fetch
//
// Instruction memory with a small load/run/halt controller. In LOAD the host
// writes words into memory; in RUN every clock edge fetches mem[prog_addr]
// into the instruction register and counts the fetch; fetching the HALT_OP
// opcode freezes the fetch path in HALT until the host re-enters LOAD.
//
// Ports
//   clk          rising-edge clock for all state
//   reset        asynchronous, active-high; forces IDLE and clears outputs
//   load_en      request to enter / stay in LOAD
//   load_valid   write strobe, honoured only in LOAD
//   load_addr    write address
//   load_data    write data
//   load_ready   high exactly while in LOAD
//   run          leave IDLE and start fetching
//   prog_addr    fetch address from the program counter
//   OPCODE       instr[6:0] of the registered instruction
//   instr        registered fetched instruction
//   rd/rs1/rs2   register fields decoded from instr
//   instr_valid  instr/OPCODE hold a fetched word
//   halted       HALT opcode has been fetched
//   fetch_count  saturating count of RUN fetches
// -----------------------------------------------------------------------------
`timescale 1ns/1ps

module instr_mem_fetch #(
    parameter int          AW      = 5,
    parameter int          DW      = 32,
    parameter logic [6:0]  HALT_OP = 7'b1010101
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          load_en,
    input  logic          load_valid,
    input  logic [AW-1:0] load_addr,
    input  logic [DW-1:0] load_data,
    output logic          load_ready,
    input  logic          run,
    input  logic [AW-1:0] prog_addr,
    output logic [6:0]    OPCODE,
    output logic [DW-1:0] instr,
    output logic [4:0]    rd,
    output logic [4:0]    rs1,
    output logic [4:0]    rs2,
    output logic          instr_valid,
    output logic          halted,
    output logic [15:0]   fetch_count
);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_LOAD = 2'd1,
        ST_RUN  = 2'd2,
        ST_HALT = 2'd3
    } state_t;

    state_t          state_reg;
    logic [DW-1:0]   instr_reg;
    logic            instr_valid_reg;
    logic            halted_reg;
    logic [15:0]     fetch_count_reg;
    logic [15:0]     fetch_count_next;
    logic [DW-1:0]   fetch_word;

    // Program storage. Deliberately not touched by reset so that a reset
    // mid-load or mid-run keeps whatever has already been written.
    logic [DW-1:0] mem [0:(2**AW)-1];

    // Writes happen only in LOAD and reads are only consumed in RUN, so the
    // two never overlap and no read-during-write behaviour is needed.
    always_ff @(posedge clk) begin
        if (state_reg == ST_LOAD && load_valid) begin
            mem[load_addr] <= load_data;
        end
    end

    // The word under prog_addr is needed before the edge so the HALT opcode
    // can steer the state on the same edge it is registered.
    assign fetch_word = mem[prog_addr];

    always_comb begin
        fetch_count_next = fetch_count_reg;
        if (fetch_count_reg != 16'hFFFF) begin
            fetch_count_next = fetch_count_reg + 16'd1;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_reg       <= ST_IDLE;
            instr_reg       <= '0;
            instr_valid_reg <= 1'b0;
            halted_reg      <= 1'b0;
            fetch_count_reg <= 16'd0;
        end else begin
            case (state_reg)
                ST_IDLE: begin
                    if (load_en) begin
                        state_reg <= ST_LOAD;
                    end else if (run) begin
                        state_reg       <= ST_RUN;
                        fetch_count_reg <= 16'd0;
                    end
                end
                ST_LOAD: begin
                    if (!load_en) begin
                        state_reg <= ST_IDLE;
                    end
                end
                ST_RUN: begin
                    if (load_en) begin
                        // Abort execution: drop the fetched word, keep the count.
                        state_reg       <= ST_LOAD;
                        instr_reg       <= '0;
                        instr_valid_reg <= 1'b0;
                        halted_reg      <= 1'b0;
                    end else begin
                        instr_reg       <= fetch_word;
                        instr_valid_reg <= 1'b1;
                        fetch_count_reg <= fetch_count_next;
                        if (fetch_word[6:0] == HALT_OP) begin
                            state_reg  <= ST_HALT;
                            halted_reg <= 1'b1;
                        end
                    end
                end
                ST_HALT: begin
                    // Everything holds; prog_addr is not looked at here.
                    if (load_en) begin
                        state_reg       <= ST_LOAD;
                        instr_reg       <= '0;
                        instr_valid_reg <= 1'b0;
                        halted_reg      <= 1'b0;
                    end
                end
                default: begin
                    state_reg <= ST_IDLE;
                end
            endcase
        end
    end

    assign load_ready  = (state_reg == ST_LOAD);
    assign instr       = instr_reg;
    assign OPCODE      = instr_reg[6:0];
    assign instr_valid = instr_valid_reg;
    assign halted      = halted_reg;
    assign fetch_count = fetch_count_reg;

    // Register-field decode, one bit per iteration.
    genvar gi;
    generate
        for (gi = 0; gi < 5; gi++) begin : g_fields
            assign rd[gi]  = instr_reg[7 + gi];
            assign rs1[gi] = instr_reg[15 + gi];
            assign rs2[gi] = instr_reg[20 + gi];
        end
    endgenerate

endmodule

// File: tb/tb_instr_mem_fetch.sv
`timescale 1ns/1ps

module tb_instr_mem_fetch;

    localparam int         AW      = 5;
    localparam int         DW      = 32;
    localparam int         DEPTH   = 1 << AW;
    localparam logic [6:0] HALT_OP = 7'h55;

    logic          clk = 1'b0;
    logic          reset;
    logic          load_en;
    logic          load_valid;
    logic [AW-1:0] load_addr;
    logic [DW-1:0] load_data;
    logic          load_ready;
    logic          run;
    logic [AW-1:0] prog_addr;
    logic [6:0]    OPCODE;
    logic [DW-1:0] instr;
    logic [4:0]    rd;
    logic [4:0]    rs1;
    logic [4:0]    rs2;
    logic          instr_valid;
    logic          halted;
    logic [15:0]   fetch_count;

    int errors = 0;
    int checks = 0;

    // Reference model: what memory should contain, and the fetch counter.
    logic [DW-1:0] model_mem [0:DEPTH-1];
    int            model_count;

    instr_mem_fetch #(.AW(AW), .DW(DW), .HALT_OP(HALT_OP)) dut (
        .clk         (clk),
        .reset       (reset),
        .load_en     (load_en),
        .load_valid  (load_valid),
        .load_addr   (load_addr),
        .load_data   (load_data),
        .load_ready  (load_ready),
        .run         (run),
        .prog_addr   (prog_addr),
        .OPCODE      (OPCODE),
        .instr       (instr),
        .rd          (rd),
        .rs1         (rs1),
        .rs2         (rs2),
        .instr_valid (instr_valid),
        .halted      (halted),
        .fetch_count (fetch_count)
    );

    always #5 clk = ~clk;

    initial begin
        #5_000_000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    // Advance one edge, then sample 1 ns later.
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Stimulus only: write one word while in LOAD and record it in the model.
    task automatic write_word(input logic [AW-1:0] a, input logic [DW-1:0] d);
        load_valid = 1'b1;
        load_addr  = a;
        load_data  = d;
        step();
        model_mem[a] = d;
        load_valid = 1'b0;
    endtask

    task automatic test_reset();
        reset = 1'b1; load_en = 0; load_valid = 0; load_addr = '0; load_data = '0;
        run = 0; prog_addr = '0;
        #12;
        checks++;
        if ({instr, OPCODE, instr_valid, halted, fetch_count, load_ready} !== '0) begin
            errors++;
            $display("FAIL reset_state: instr=%h op=%h v=%b h=%b cnt=%h rdy=%b, required all zero",
                     instr, OPCODE, instr_valid, halted, fetch_count, load_ready);
        end
        @(negedge clk);
        reset = 1'b0;
        step();
        checks++;
        if (load_ready !== 1'b0) begin
            errors++; $display("FAIL idle_ready: got %b required 0", load_ready);
        end
        $display("test_reset done");
    endtask

    task automatic test_load();
        logic [DW-1:0] vals [4];
        vals = '{32'h00000013, 32'h00000033, 32'h00000055, 32'h00000013};
        load_en = 1'b1;
        step();
        checks++;
        if (load_ready !== 1'b1) begin
            errors++; $display("FAIL load_ready_enter: got %b required 1", load_ready);
        end
        for (int i = 0; i < 4; i++) begin
            write_word(i[AW-1:0], vals[i]);
            checks++;
            if (load_ready !== 1'b1) begin
                errors++; $display("FAIL load_ready_beat%0d: got %b required 1", i, load_ready);
            end
        end
        load_en = 1'b0;
        step();
        checks++;
        if ({load_ready, instr_valid, OPCODE} !== 9'd0) begin
            errors++;
            $display("FAIL load_exit: rdy=%b v=%b op=%h required 0/0/00", load_ready, instr_valid, OPCODE);
        end
        $display("test_load done");
    endtask

    task automatic test_run_halt();
        logic exp_halt;
        run = 1'b1;
        step();
        run = 1'b0;
        model_count = 0;
        checks++;
        if ({fetch_count, instr_valid} !== {16'd0, 1'b0}) begin
            errors++; $display("FAIL run_entry: cnt=%0d v=%b required 0/0", fetch_count, instr_valid);
        end
        for (int i = 0; i < 3; i++) begin
            prog_addr = i[AW-1:0];
            step();
            model_count++;
            exp_halt = (model_mem[i][6:0] == HALT_OP);
            checks++;
            if ({instr, OPCODE, instr_valid, halted, fetch_count} !==
                {model_mem[i], model_mem[i][6:0], 1'b1, exp_halt, model_count[15:0]}) begin
                errors++;
                $display("FAIL run_fetch%0d: instr=%h op=%h v=%b h=%b cnt=%0d required %h/%h/1/%b/%0d",
                         i, instr, OPCODE, instr_valid, halted, fetch_count,
                         model_mem[i], model_mem[i][6:0], exp_halt, model_count);
            end
        end
        for (int k = 0; k < 4; k++) begin
            prog_addr = AW'($urandom);
            step();
            checks++;
            if ({instr, instr_valid, halted, fetch_count} !== {model_mem[2], 1'b1, 1'b1, 16'd3}) begin
                errors++;
                $display("FAIL halt_hold%0d: instr=%h v=%b h=%b cnt=%0d required %h/1/1/3",
                         k, instr, instr_valid, halted, fetch_count, model_mem[2]);
            end
        end
        $display("test_run_halt done");
    endtask

    task automatic test_priority();
        load_en = 1'b1;
        step();
        checks++;
        if ({load_ready, halted, instr_valid, instr, fetch_count} !== {3'b100, 32'd0, 16'd3}) begin
            errors++;
            $display("FAIL halt_to_load: rdy=%b h=%b v=%b instr=%h cnt=%0d required 1/0/0/0/3",
                     load_ready, halted, instr_valid, instr, fetch_count);
        end
        load_en = 1'b0;
        step();
        load_en = 1'b1;
        run     = 1'b1;
        step();
        checks++;
        if ({load_ready, fetch_count} !== {1'b1, 16'd3}) begin
            errors++;
            $display("FAIL load_priority: rdy=%b cnt=%0d required 1/3", load_ready, fetch_count);
        end
        load_en = 1'b0;
        run     = 1'b0;
        step();
        $display("test_priority done");
    endtask

    task automatic test_decode();
        load_en = 1'b1;
        step();
        write_word(5, 32'h00A50533);
        load_en = 1'b0;
        step();
        run = 1'b1;
        step();
        run = 1'b0;
        prog_addr = 5;
        step();
        checks++;
        if ({rd, rs1, rs2, OPCODE} !== {5'd10, 5'd10, 5'd10, 7'h33}) begin
            errors++;
            $display("FAIL decode: rd=%0d rs1=%0d rs2=%0d op=%h required 10/10/10/33", rd, rs1, rs2, OPCODE);
        end
        load_en = 1'b1;
        step();
        load_en = 1'b0;
        step();
        $display("test_decode done");
    endtask

    task automatic test_reset_mid();
        // Mid-run reset clears outputs without a clock edge.
        run = 1'b1;
        step();
        run = 1'b0;
        prog_addr = 3;
        step();
        checks++;
        if (instr !== model_mem[3]) begin
            errors++; $display("FAIL readback3: got %h required %h", instr, model_mem[3]);
        end
        step();
        #2;
        reset = 1'b1;
        #1;
        checks++;
        if ({instr, OPCODE, instr_valid, halted, fetch_count, load_ready} !== '0) begin
            errors++;
            $display("FAIL async_reset_run: instr=%h op=%h v=%b h=%b cnt=%h rdy=%b required all zero",
                     instr, OPCODE, instr_valid, halted, fetch_count, load_ready);
        end
        @(negedge clk);
        reset = 1'b0;
        run = 1'b1;
        step();
        run = 1'b0;
        checks++;
        if ({instr_valid, fetch_count} !== 17'd0) begin
            errors++; $display("FAIL rerun_entry: v=%b cnt=%0d required 0/0", instr_valid, fetch_count);
        end
        prog_addr = 3;
        step();
        checks++;
        if ({instr, fetch_count} !== {model_mem[3], 16'd1}) begin
            errors++;
            $display("FAIL rerun_fetch: instr=%h cnt=%0d required %h/1", instr, fetch_count, model_mem[3]);
        end
        load_en = 1'b1;
        step();
        // Mid-load reset: the word already written survives.
        write_word(9, 32'hDEADBE13);
        load_valid = 1'b1;
        load_addr  = 10;
        load_data  = 32'h12345678;
        #2;
        reset = 1'b1;
        #1;
        checks++;
        if (load_ready !== 1'b0) begin
            errors++; $display("FAIL async_reset_load: rdy=%b required 0", load_ready);
        end
        @(negedge clk);
        reset = 1'b0; load_en = 1'b0; load_valid = 1'b0;
        run = 1'b1;
        step();
        run = 1'b0;
        prog_addr = 9;
        step();
        checks++;
        if (instr !== model_mem[9]) begin
            errors++; $display("FAIL load_retained: got %h required %h", instr, model_mem[9]);
        end
        load_en = 1'b1;
        step();
        load_en = 1'b0;
        step();
        $display("test_reset_mid done");
    endtask

    task automatic test_random();
        logic [DW-1:0] d;
        logic [DW-1:0] exp_instr;
        logic          mhalt;
        logic [AW-1:0] a;
        // Fill every word, with idle gaps; roughly one word in eight is HALT.
        load_en = 1'b1;
        step();
        for (int i = 0; i < DEPTH; i++) begin
            if ($urandom_range(0, 2) == 0) begin
                load_valid = 1'b0;
                load_addr  = AW'($urandom);
                load_data  = $urandom;
                step();
            end
            d = $urandom;
            if ($urandom_range(0, 7) == 0) d[6:0] = HALT_OP;
            else if (d[6:0] == HALT_OP) d[6:0] = 7'h13;
            write_word(i[AW-1:0], d);
        end
        load_en = 1'b0;
        step();
        // A write strobe outside LOAD must not reach memory.
        load_valid = 1'b1;
        load_addr  = 7;
        load_data  = ~model_mem[7];
        step();
        load_valid = 1'b0;
        for (int r = 0; r < 4; r++) begin
            run = 1'b1;
            step();
            run = 1'b0;
            model_count = 0;
            mhalt = 1'b0;
            exp_instr = '0;
            for (int k = 0; k < 30; k++) begin
                a = (k == 0 && r == 0) ? AW'(7) : AW'($urandom);
                prog_addr  = a;
                load_valid = 1'($urandom);
                load_addr  = AW'($urandom);
                load_data  = $urandom;
                step();
                if (!mhalt) begin
                    exp_instr = model_mem[a];
                    model_count++;
                    mhalt = (exp_instr[6:0] == HALT_OP);
                end
                checks++;
                if ({instr, instr_valid, halted, fetch_count, rd, rs1, rs2} !==
                    {exp_instr, 1'b1, mhalt, model_count[15:0],
                     exp_instr[11:7], exp_instr[19:15], exp_instr[24:20]}) begin
                    errors++;
                    $display("FAIL rand_r%0d_k%0d: instr=%h v=%b h=%b cnt=%0d rd=%0d rs1=%0d rs2=%0d required %h/1/%b/%0d",
                             r, k, instr, instr_valid, halted, fetch_count, rd, rs1, rs2,
                             exp_instr, mhalt, model_count);
                end
            end
            load_valid = 1'b0;
            load_en = 1'b1;
            step();
            checks++;
            if ({load_ready, instr_valid, halted, instr, fetch_count} !==
                {3'b100, 32'd0, model_count[15:0]}) begin
                errors++;
                $display("FAIL rand_abort%0d: rdy=%b v=%b h=%b instr=%h cnt=%0d required 1/0/0/0/%0d",
                         r, load_ready, instr_valid, halted, instr, fetch_count, model_count);
            end
            load_en = 1'b0;
            step();
        end
        $display("test_random done");
    endtask

    task automatic test_saturation();
        load_en = 1'b1;
        step();
        write_word(0, 32'h00000013);
        load_en = 1'b0;
        step();
        run = 1'b1;
        step();
        run = 1'b0;
        prog_addr = 0;
        model_count = 0;
        for (int i = 0; i < 65540; i++) begin
            step();
            model_count = (model_count < 65535) ? model_count + 1 : 65535;
        end
        checks++;
        if ({fetch_count, instr_valid, halted} !== {model_count[15:0], 1'b1, 1'b0}) begin
            errors++;
            $display("FAIL saturate: cnt=%h v=%b h=%b required %h/1/0", fetch_count, instr_valid, halted, model_count[15:0]);
        end
        repeat (3) step();
        checks++;
        if (fetch_count !== 16'hFFFF) begin
            errors++; $display("FAIL saturate_hold: cnt=%h required ffff", fetch_count);
        end
        $display("test_saturation done");
    endtask

    initial begin
        test_reset();
        test_load();
        test_run_halt();
        test_priority();
        test_decode();
        test_reset_mid();
        test_random();
        test_saturation();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/instr_mem_fetch.md
INSTR_MEM_FETCH -- requirements
Module: instr_mem_fetch

Interface
REQ-001 Parameter AW, default 5, instruction address width; SHALL match the width of prog_addr.
REQ-002 Parameter DW, default 32, instruction word width.
REQ-003 Parameter HALT_OP, default 7'b1010101, opcode value that SHALL be treated as HALT.
REQ-004 clk  input  1  rising-edge clock for all state.
REQ-005 reset  input  1  reset, asynchronous, active-high.
REQ-006 load_en  input  1  request to enter or remain in load mode.
REQ-007 load_valid  input  1  load beat valid.
REQ-008 load_addr  input  AW  load write address.
REQ-009 load_data  input  DW  load write data.
REQ-010 load_ready  output  1  block accepts load beats.
REQ-011 run  input  1  start execution from IDLE.
REQ-012 prog_addr  input  AW  fetch address from the program counter.
REQ-013 OPCODE  output  7  registered instr[6:0], fed back to the program counter.
REQ-014 instr  output  DW  registered fetched instruction.
REQ-015 rd / rs1 / rs2  output  5 each  instr[11:7] / instr[19:15] / instr[24:20], combinational from instr.
REQ-016 instr_valid  output  1  instr/OPCODE hold a fetched instruction.
REQ-017 halted  output  1  HALT opcode has been fetched.
REQ-018 fetch_count  output  16  number of fetches performed in RUN.

Function
REQ-019 Storage SHALL be 2**AW words of DW bits; contents SHALL NOT be cleared by reset.
REQ-020 The FSM SHALL have exactly four states: IDLE, LOAD, RUN, HALT.
REQ-021 In IDLE: load_en=1 -> LOAD; else run=1 -> RUN; else stay. load_en has priority over run.
REQ-022 In LOAD: load_ready SHALL be 1; a write to mem[load_addr] SHALL occur on each edge with load_valid=1; load_en=0 -> IDLE.
REQ-023 load_ready SHALL be 0 in all states other than LOAD; load_valid outside LOAD SHALL be ignored.
REQ-024 In RUN: each edge SHALL register instr <= mem[prog_addr] with one-cycle latency, set instr_valid=1, and increment fetch_count.
REQ-025 fetch_count SHALL saturate at 16'hFFFF.
REQ-026 In RUN: when the value being registered has [6:0]==HALT_OP, the next state SHALL be HALT, halted=1 on the same edge, and OPCODE SHALL equal HALT_OP.
REQ-027 In HALT: instr, OPCODE, instr_valid, halted and fetch_count SHALL hold; prog_addr SHALL be ignored.
REQ-028 In RUN or HALT: load_en=1 -> LOAD on the next edge, clearing instr to 0, OPCODE to 0, instr_valid to 0 and halted to 0; fetch_count SHALL hold.
REQ-029 A transition IDLE -> RUN SHALL clear fetch_count to 0 on the same edge.
REQ-030 In IDLE and LOAD, instr_valid SHALL be 0 and OPCODE SHALL be 0.
REQ-031 In LOAD, a write and a RUN fetch cannot coincide; there SHALL be no read-during-write path.

Reset
REQ-032 reset=1 SHALL asynchronously force IDLE and drive instr=0, OPCODE=0, instr_valid=0, halted=0, fetch_count=0 and load_ready=0.
REQ-033 Reset asserted mid-LOAD SHALL abort the load; words already written SHALL be retained.
REQ-034 Reset asserted mid-RUN or in HALT SHALL return to IDLE; the first fetch after a new run SHALL occur one edge after entry to RUN.

Verification
REQ-035 Load: load_en=1, write mem[0..3]=0x00000013,0x00000033,0x00000055,0x00000013 (load_valid each cycle) -> load_ready=1 throughout; readback in RUN matches.
REQ-036 Run and halt: after REQ-035 load, run=1 and prog_addr stepping 0,1,2 -> OPCODE 0x13, 0x33, 0x55 on successive edges; halted=1 and state HALT with fetch_count=3; prog_addr changes afterwards -> outputs unchanged.
REQ-037 Decode: mem[5]=0x00A50533, fetch at prog_addr=5 -> rd=10, rs1=10, rs2=10, OPCODE=0x33.
REQ-038 Priority and abort: load_en=1 and run=1 together in IDLE -> LOAD; load_en=1 in HALT -> LOAD next edge with halted=0 and instr_valid=0.
REQ-039 Reset: reset pulse mid-RUN -> all outputs 0 immediately (no clock edge); a previously loaded word is still read correctly on rerun.
REQ-040 Saturation: 65540 RUN fetches with no HALT_OP in memory -> fetch_count=16'hFFFF and held.
